// File: rtl/scroll_pkg.sv
// Shared constants and FSM state type for the scrolling-text column generator.
package scroll_pkg;

  localparam int unsigned CHAR_W    = 6;  // font columns plus one blank spacer
  localparam int unsigned FONT_COLS = 5;
  localparam int unsigned FONT_ROWS = 7;
  localparam int unsigned ASCII_W   = 7;
  localparam int unsigned ROW_W     = 3;
  localparam int unsigned SUB_W     = 3;

  // Sub-column index of the blank spacer that follows every glyph
  localparam logic [SUB_W-1:0] BLANK_SUB = SUB_W'(CHAR_W - 1);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    BLANK   = 2'd1,
    PRESENT = 2'd2
  } scroll_state_e;

endpackage

// File: rtl/scroll_tick_gen.sv
// Scroll-rate prescaler: one-cycle tick every TICK_DIV clock cycles.
module scroll_tick_gen #(
  parameter int unsigned TICK_DIV = 1000000
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam int unsigned CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic             tick_q;
  logic             wrap_c;

  assign wrap_c = (cnt_q == CNT_W'(TICK_DIV - 1));

  // Free-running counter 0..TICK_DIV-1 with a registered pulse at the wrap
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= wrap_c ? '0 : cnt_q + CNT_W'(1);
      tick_q <= wrap_c;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/scroll_column_gen.sv
// Column-stream generator for the scrolling-text OLED path: walks the message,
// addresses the font ROM row by row, and streams VIEW_COLS pixel columns per
// frame. The scroll offset only moves at frame boundaries so frames never tear.
// Optional feature: define SCROLL_PAUSE_EN to add a `pause` input that holds
// the scroll offset while frames keep streaming.
module scroll_column_gen
  import scroll_pkg::*;
#(
  parameter int unsigned MSG_LEN   = 5,
  parameter int unsigned VIEW_COLS = 96,
  parameter int unsigned TICK_DIV  = 1000000
) (
  input  logic                        clk,
  input  logic                        rst,
`ifdef SCROLL_PAUSE_EN
  input  logic                        pause,
`endif
  input  logic [ASCII_W*MSG_LEN-1:0]  msg,
  output logic [ASCII_W-1:0]          rom_char,
  output logic [ROW_W-1:0]            rom_row,
  input  logic [FONT_COLS-1:0]        rom_pixels,
  output logic [FONT_ROWS-1:0]        col_data,
  output logic                        col_valid,
  input  logic                        col_ready,
  output logic                        col_first
);

  localparam int unsigned CIDX_W = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
  localparam int unsigned X_W    = (VIEW_COLS > 1) ? $clog2(VIEW_COLS) : 1;

  // Strip position as character index plus sub-column (0..5)
  typedef struct packed {
    logic [CIDX_W-1:0] ch;
    logic [SUB_W-1:0]  sub;
  } pos_t;

  // Advance one strip column, wrapping the last character back to the first
  function automatic pos_t pos_inc(input pos_t p);
    pos_t r;
    r = p;
    if (p.sub == BLANK_SUB) begin
      r.sub = '0;
      r.ch  = (p.ch == CIDX_W'(MSG_LEN - 1)) ? '0 : p.ch + CIDX_W'(1);
    end else begin
      r.sub = p.sub + SUB_W'(1);
    end
    return r;
  endfunction

  scroll_state_e         state_q;
  pos_t                  pos_q;
  pos_t                  off_q;
  logic [X_W-1:0]        x_q;
  logic                  pend_q;
  logic [FONT_ROWS-1:0]  shift_q;
  logic [FONT_ROWS-1:0]  col_data_q;
  logic                  col_valid_q;
  logic                  col_first_q;
  logic [ROW_W-1:0]      rom_row_q;

  logic                  tick_c;
  logic                  pause_c;
  logic                  accept_c;
  logic                  frame_end_c;
  logic                  step_c;
  logic                  pend_d;
  logic                  pixel_c;
  logic [FONT_ROWS-1:0]  shift_d;
  pos_t                  off_d;
  pos_t                  pos_d;

  logic [ASCII_W-1:0]    msg_arr [MSG_LEN];

  // Unpack the flat message bus into per-character entries
  for (genvar i = 0; i < MSG_LEN; i++) begin : g_msg
    assign msg_arr[i] = msg[i*ASCII_W +: ASCII_W];
  end

`ifdef SCROLL_PAUSE_EN
  assign pause_c = pause;
`else
  assign pause_c = 1'b0;
`endif

  scroll_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk_i  (clk),
    .rst_i  (rst),
    .tick_o (tick_c)
  );

  // Handshake, frame-end and scroll-step decode plus next strip position
  always_comb begin
    accept_c    = 1'b0;
    frame_end_c = 1'b0;
    step_c      = 1'b0;
    off_d       = off_q;
    pos_d       = pos_q;
    pixel_c     = 1'b0;
    shift_d     = shift_q;

    accept_c    = (state_q == PRESENT) && col_valid_q && col_ready;
    frame_end_c = accept_c && (x_q == X_W'(VIEW_COLS - 1));
    step_c      = frame_end_c && pend_q && !pause_c;

    if (step_c) begin
      off_d = pos_inc(off_q);
    end

    if (frame_end_c) begin
      pos_d = off_d;
    end else if (accept_c) begin
      pos_d = pos_inc(pos_q);
    end

    if (state_q == FETCH) begin
      pixel_c = rom_pixels[SUB_W'(FONT_COLS - 1) - pos_q.sub];
    end
    // Row r lands in bit r after all seven rows have shifted in from the top
    shift_d = {pixel_c, shift_q[FONT_ROWS-1:1]};
  end

  // A tick raised on the frame-end cycle survives to the following frame end
  assign pend_d = (pend_q && !step_c) || tick_c;

  // Column FSM: fetch glyph rows or insert a blank, then present until accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FETCH;
      pos_q       <= '0;
      off_q       <= '0;
      x_q         <= '0;
      pend_q      <= 1'b0;
      shift_q     <= '0;
      col_data_q  <= '0;
      col_valid_q <= 1'b0;
      col_first_q <= 1'b0;
      rom_row_q   <= '0;
    end else begin
      pend_q <= pend_d;
      case (state_q)
        FETCH: begin
          shift_q <= shift_d;
          if (rom_row_q == ROW_W'(FONT_ROWS - 1)) begin
            col_data_q  <= shift_d;
            col_valid_q <= 1'b1;
            col_first_q <= (x_q == '0);
            rom_row_q   <= '0;
            state_q     <= PRESENT;
          end else begin
            rom_row_q <= rom_row_q + ROW_W'(1);
          end
        end
        BLANK: begin
          col_data_q  <= '0;
          col_valid_q <= 1'b1;
          col_first_q <= (x_q == '0);
          state_q     <= PRESENT;
        end
        PRESENT: begin
          if (accept_c) begin
            col_valid_q <= 1'b0;
            col_first_q <= 1'b0;
            pos_q       <= pos_d;
            off_q       <= off_d;
            x_q         <= frame_end_c ? '0 : x_q + X_W'(1);
            rom_row_q   <= '0;
            state_q     <= (pos_d.sub == BLANK_SUB) ? BLANK : FETCH;
          end
        end
        default: begin
          state_q <= FETCH;
        end
      endcase
    end
  end

  // The message is static outside reset, so this follows the registered index
  assign rom_char  = msg_arr[pos_q.ch];
  assign rom_row   = rom_row_q;
  assign col_data  = col_data_q;
  assign col_valid = col_valid_q;
  assign col_first = col_first_q;

endmodule

// File: tb/tb_scroll_column_gen.sv
// Bench for scroll_column_gen: a default-size instance for the HELLO frame,
// backpressure and reset checks, and a small fast-scrolling instance for the
// offset stepping, wrap, random message and (with SCROLL_PAUSE_EN) pause checks.
module tb_scroll_column_gen;

  localparam int unsigned S    = 30;
  localparam int unsigned VC_A = 96;
  localparam int unsigned VC_B = 8;
  localparam logic [34:0] HELLO = {7'h4F, 7'h4C, 7'h4C, 7'h45, 7'h48};

  logic        clk = 1'b0;
  logic        rst;
  logic [34:0] msg;

  logic [6:0]  rom_char_a, rom_char_b;
  logic [2:0]  rom_row_a, rom_row_b;
  logic [4:0]  rom_pix_a, rom_pix_b;
  logic [6:0]  col_data_a, col_data_b;
  logic        col_valid_a, col_valid_b;
  logic        col_ready_a, col_ready_b;
  logic        col_first_a, col_first_b;
`ifdef SCROLL_PAUSE_EN
  logic        pause_b;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  // 5x7 glyphs, row 0 in the top five bits, bit 4 of each row = leftmost pixel
  function automatic logic [34:0] glyph(input logic [6:0] ch);
    case (ch)
      7'h48:   return 35'b10001_10001_10001_11111_10001_10001_10001; // H
      7'h45:   return 35'b11111_10000_10000_11110_10000_10000_11111; // E
      7'h4C:   return 35'b10000_10000_10000_10000_10000_10000_11111; // L
      7'h4F:   return 35'b01110_10001_10001_10001_10001_10001_01110; // O
      default: return {ch, ch, ch, ch, ch} ^ 35'h2A5A5A5A5;
    endcase
  endfunction

  function automatic logic [4:0] font(input logic [6:0] ch, input logic [2:0] row);
    logic [34:0] g;
    g = glyph(ch);
    if (row > 3'd6) return 5'd0;
    return g[34 - 5*int'(row) -: 5];
  endfunction

  // Expected column x of a frame scrolled by `off`, straight from the strip rules
  function automatic logic [6:0] exp_col(input logic [34:0] m, input int off, input int x);
    int          p;
    int          c;
    logic [6:0]  ch;
    logic [4:0]  f;
    logic [6:0]  col;
    p   = (off + x) % S;
    c   = p % 6;
    ch  = m[7*(p/6) +: 7];
    col = '0;
    if (c == 5) return col;
    for (int r = 0; r < 7; r++) begin
      f      = font(ch, 3'(r));
      col[r] = f[4-c];
    end
    return col;
  endfunction

  assign rom_pix_a = font(rom_char_a, rom_row_a);
  assign rom_pix_b = font(rom_char_b, rom_row_b);

  scroll_column_gen #(.MSG_LEN(5), .VIEW_COLS(VC_A), .TICK_DIV(1000000)) dut_a (
    .clk        (clk),
    .rst        (rst),
`ifdef SCROLL_PAUSE_EN
    .pause      (1'b0),
`endif
    .msg        (msg),
    .rom_char   (rom_char_a),
    .rom_row    (rom_row_a),
    .rom_pixels (rom_pix_a),
    .col_data   (col_data_a),
    .col_valid  (col_valid_a),
    .col_ready  (col_ready_a),
    .col_first  (col_first_a)
  );

  scroll_column_gen #(.MSG_LEN(5), .VIEW_COLS(VC_B), .TICK_DIV(4)) dut_b (
    .clk        (clk),
    .rst        (rst),
`ifdef SCROLL_PAUSE_EN
    .pause      (pause_b),
`endif
    .msg        (msg),
    .rom_char   (rom_char_b),
    .rom_row    (rom_row_b),
    .rom_pixels (rom_pix_b),
    .col_data   (col_data_b),
    .col_valid  (col_valid_b),
    .col_ready  (col_ready_b),
    .col_first  (col_first_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for a column handshake with random ready; returns its payload
  task automatic get_col(input bit b, input int ready_pct, output logic [6:0] d, output logic f);
    int n;
    bit got;
    n   = 0;
    got = 1'b0;
    d   = 'x;
    f   = 1'bx;
    while (!got && n < 200) begin
      @(negedge clk);
      n++;
      if (b) begin
        col_ready_b = ($urandom_range(0, 99) < ready_pct);
        if (col_valid_b && col_ready_b) begin
          d = col_data_b; f = col_first_b; got = 1'b1;
        end
      end else begin
        col_ready_a = ($urandom_range(0, 99) < ready_pct);
        if (col_valid_a && col_ready_a) begin
          d = col_data_a; f = col_first_a; got = 1'b1;
        end
      end
    end
    if (!got) begin
      tests_run++;
      tests_failed++;
      $error("FAIL get_col_timeout: no handshake within 200 cycles (dut %0d)", b);
    end
  endtask

  initial begin
    logic [6:0] d;
    logic       f;
    int         n;

    rst         = 1'b1;
    msg         = HELLO;
    col_ready_a = 1'b0;
    col_ready_b = 1'b0;
`ifdef SCROLL_PAUSE_EN
    pause_b     = 1'b0;
`endif

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(col_valid_a), 32'd0);
    check("rst_data",  32'(col_data_a),  32'd0);
    check("rst_first", 32'(col_first_a), 32'd0);
    check("rst_row",   32'(rom_row_a),   32'd0);
    check("rst_char",  32'(rom_char_a),  32'h48);

    // First glyph column: rows 0..6 on cycles 0..6, valid on cycle 7
    rst         = 1'b0;
    col_ready_a = 1'b1;
    for (int i = 0; i < 7; i++) begin
      check($sformatf("row_seq%0d", i), 32'({col_valid_a, rom_row_a}), 32'(i));
      @(negedge clk);
    end
    check("c0_valid", 32'(col_valid_a), 32'd1);
    check("c0_data",  32'(col_data_a),  32'h7F);
    check("c0_first", 32'(col_first_a), 32'd1);

    // Backpressure on column 1
    @(negedge clk);
    col_ready_a = 1'b0;
    n = 0;
    while (!col_valid_a && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("c1_valid", 32'(col_valid_a), 32'd1);
    check("c1_first", 32'(col_first_a), 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("bp_hold%0d", i), 32'({col_valid_a, col_data_a}), 32'h88);
    end
    col_ready_a = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!col_valid_a && n < 20);
    check("c2_latency", 32'(n), 32'd8);
    check("c2_data", 32'(col_data_a), 32'h08);

    // Asynchronous reset in the middle of column 3's fetch
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(col_valid_a), 32'd0);
    check("mid_rst_data",  32'(col_data_a),  32'd0);
    check("mid_rst_first", 32'(col_first_a), 32'd0);
    check("mid_rst_row",   32'(rom_row_a),   32'd0);
    check("mid_rst_char",  32'(rom_char_a),  32'h48);
    @(negedge clk);
    rst = 1'b0;

    // Full 96-column frame with random backpressure, then next frame's start
    for (int x = 0; x < int'(VC_A); x++) begin
      get_col(1'b0, 70, d, f);
      check($sformatf("a_data_x%0d", x), 32'(d), 32'(exp_col(msg, 0, x)));
      check($sformatf("a_first_x%0d", x), 32'(f), 32'(x == 0));
    end
    get_col(1'b0, 70, d, f);
    check("a_f1_data",  32'(d), 32'h7F);
    check("a_f1_first", 32'(f), 32'd1);
    col_ready_a = 1'b0;

    // Fast scroll: one step per frame, through the wrap back to offset 0
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int fr = 0; fr < 32; fr++) begin
      for (int x = 0; x < int'(VC_B); x++) begin
        get_col(1'b1, 75, d, f);
        check($sformatf("b_data_f%0d_x%0d", fr, x), 32'(d), 32'(exp_col(msg, fr % S, x)));
        check($sformatf("b_first_f%0d_x%0d", fr, x), 32'(f), 32'(x == 0));
      end
    end

    // Random printable message
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) msg[7*i +: 7] = 7'($urandom_range(32, 126));
    @(negedge clk);
    rst = 1'b0;
    for (int fr = 0; fr < 3; fr++) begin
      for (int x = 0; x < int'(VC_B); x++) begin
        get_col(1'b1, 60, d, f);
        check($sformatf("r_data_f%0d_x%0d", fr, x), 32'(d), 32'(exp_col(msg, fr, x)));
      end
    end

`ifdef SCROLL_PAUSE_EN
    // Pause holds the offset across frames; releasing it steps at the next frame end
    @(negedge clk);
    rst     = 1'b1;
    msg     = HELLO;
    pause_b = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int fr = 0; fr < 7; fr++) begin
      for (int x = 0; x < int'(VC_B); x++) begin
        get_col(1'b1, 75, d, f);
        check($sformatf("p_data_f%0d_x%0d", fr, x), 32'(d),
              32'(exp_col(msg, (fr <= 4) ? 0 : fr - 4, x)));
        if (fr == 4 && x == 0) pause_b = 1'b0;
      end
    end
`endif

    col_ready_b = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/scroll_column_gen.md
# scroll_column_gen

Column-stream generator for the scrolling-text OLED path. It walks a fixed message, addresses the 5x7 font ROM one row at a time, and assembles 7-bit pixel columns. It emits one display frame of `VIEW_COLS` columns per pass to the downstream OLED column writer over a valid/ready handshake. A scroll offset advances by one column per scroll tick, and only at frame boundaries, so a frame never tears.

## Interface
- `MSG_LEN`, 5: number of characters in `msg`.
- `VIEW_COLS`, 96: columns per display frame.
- `TICK_DIV`, 1000000: clock cycles per scroll step (≥2).
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `msg`  in  7*MSG_LEN  ASCII message; char i at bits [7i+6:7i], i=0 leftmost; must be static outside reset.
- `rom_char`  out  7  font ROM character address.
- `rom_row`  out  3  font ROM row address (0 = top).
- `rom_pixels`  in  5  ROM data, combinational from address; bit 4 = leftmost pixel.
- `col_data`  out  7  pixel column; bit r = row r (bit 0 = top).
- `col_valid`  out  1  column available.
- `col_ready`  in  1  downstream accepts.
- `col_first`  out  1  qualifies `col_data`: first column of a frame.

## Operation
- Strip length S = MSG_LEN*6 columns. Each char occupies 6 columns: font cols 0–4, then one blank column (5).
- State: `offset` in [0,S-1]; view column `x` in [0,VIEW_COLS-1]; strip position `p` tracked as `char_idx` in [0,MSG_LEN-1] plus `sub` in [0,5]. No divider: `p` is an incrementing counter.
- Frame start: `p` ← `offset`; `x` ← 0.
- After each accepted column: `sub`+1; when `sub`=5 it wraps to 0 and `char_idx`+1, which wraps MSG_LEN-1→0. `VIEW_COLS` > S repeats the message.
- FSM states:
  - FETCH: only when `sub`<5. `rom_char` = msg[char_idx]; `rom_row` counts 0..6, one per cycle; bit `rom_row` of shift register ← `rom_pixels[4-sub]`. After row 6 → PRESENT.
  - BLANK: only when `sub`=5. Column register ← 0 in one cycle → PRESENT.
  - PRESENT: `col_valid`=1. On `col_valid && col_ready`:
    - if `x`=VIEW_COLS-1: frame end, apply pending offset step, restart at frame start;
    - else advance `p` and `x`.
    - Then FETCH or BLANK by the new `sub`.
- `col_first`=1 while presenting `x`=0.
- Scroll step: `scroll_tick_gen` pulses `tick` every TICK_DIV cycles and sets `tick_pending`. At frame end, if pending: `offset` ← (`offset`+1 == S) ? 0 : `offset`+1, and pending clears. Multiple ticks within one frame collapse to a single step. A tick arriving on the same cycle as frame end is applied at the next frame end.
- Reset (any time, including mid-fetch/present):
  - `offset`=0, `x`=0, `char_idx`=0, `sub`=0, `tick_pending`=0, prescaler=0, state FETCH.
  - `col_valid`=0, `col_data`=0, `col_first`=0, `rom_row`=0, `rom_char`=msg[0].

## Timing
- Glyph column: ROM addressed for rows 0..6 on cycles 0..6 after entry to FETCH; `col_valid` rises on cycle 7.
- Blank column: `col_valid` 1 cycle after entry.
- Back-to-back with `col_ready` held high: 8 cycles per glyph column, 2 per blank column.
- `col_data`/`col_first` are registered and stable while `col_valid`=1 and not accepted. `col_valid` never drops without a handshake.
- `rom_char`/`rom_row` are registered; the ROM is combinational, so data is captured the same cycle.

## Configuration
- `SCROLL_PAUSE_EN` defined:
  - Adds input port `pause` (1 bit).
  - While `pause`=1, the frame-end offset step is suppressed and `tick_pending` is retained.
  - The step applies at the first frame end with `pause`=0.
  - Frames continue streaming throughout.
- Undefined: no `pause` port; behaviour as above.

## Structure
- Package `scroll_pkg`: `CHAR_W`=6, `FONT_COLS`=5, `FONT_ROWS`=7, FSM state enum {FETCH, BLANK, PRESENT}, ASCII width 7.
- One sub-module, `scroll_tick_gen`: prescaler counter 0..TICK_DIV-1, one-cycle `tick` at wrap, same `clk`/`rst`.

## Test plan
- msg="HELLO", `col_ready`=1, no tick: frame columns 0..6 = 7'h7F, 7'h08, 7'h08, 7'h08, 7'h7F, 7'h00, 7'h7F (H then blank then E col0). `col_first` on column 0 only. Column 0 valid at cycle 7 after reset release.
- Backpressure: hold `col_ready`=0 for 10 cycles on column 1 → `col_valid` stays 1 and `col_data` stays 7'h08. Release → column 2 presented 8 cycles later.
- TICK_DIV=4, VIEW_COLS=8: frame 2 column 0 = 7'h08 (offset 1). Exactly one step per frame despite multiple ticks.
- Wrap: run until offset=29 → first column 7'h00 (O blank), second 7'h7F (H col0). Next step: offset=0.
- Assert `rst` mid-FETCH of column 3 → outputs reset values immediately. After release, column 0 = 7'h7F with `col_first`=1.
- `SCROLL_PAUSE_EN`, `pause`=1 across 3 frames with ticks → offset unchanged. Drop `pause` → offset+1 at the next frame end.
